patch_gen: RTL and testbench

PATCH_GEN -- requirements
Module: patch_gen

---
 rtl/patch_gen_pkg.sv | 20 ++
 rtl/patch_gen_if.sv | 44 ++++
 rtl/patch_gen_line_buffer.sv | 33 +++
 rtl/patch_gen.sv | 204 ++++++++++++++++++++
 tb/tb_patch_gen.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/patch_gen_pkg.sv
// patch_gen_pkg: constants, types and helpers shared by the patch_gen block.
//   PixW       - width of one pixel (16 bits)
//   state_e    - frame-level FSM state
//   patch_idx  - flat element index r*K+c of a window element inside PATCH
package patch_gen_pkg;

    localparam int unsigned PixW = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,  // no pixel of the current frame accepted yet
        StActive   = 2'd1,  // frame in progress
        StHoldLast = 2'd2   // final pixel accepted, final patch not yet taken
    } state_e;

    function automatic int unsigned patch_idx(input int unsigned r, input int unsigned c,
                                              input int unsigned k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/patch_gen_if.sv
// patch_gen_if: pixel-in / patch-out stream bundle for patch_gen.
//   PIX_IN, PIX_VALID, PIX_READY       - raster pixel stream into the block
//   PATCH, PATCH_VALID, PATCH_READY    - KxK window stream out of the block
//   BUSY                               - a frame is in progress
//   PATCH_LAST                         - final patch of a frame (only with PATCH_GEN_LAST_EN)
// Modports: slave = patch_gen side, master = producer/consumer side.
interface patch_gen_if
    import patch_gen_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = 3
) ();

    logic [PixW-1:0]                         PIX_IN;
    logic                                    PIX_VALID;
    logic                                    PIX_READY;
    logic [KERNEL_SIZE*KERNEL_SIZE*PixW-1:0] PATCH;
    logic                                    PATCH_VALID;
    logic                                    PATCH_READY;
    logic                                    BUSY;
`ifdef PATCH_GEN_LAST_EN
    logic                                    PATCH_LAST;

    modport slave (
        input  PIX_IN, PIX_VALID, PATCH_READY,
        output PIX_READY, PATCH, PATCH_VALID, BUSY, PATCH_LAST
    );

    modport master (
        output PIX_IN, PIX_VALID, PATCH_READY,
        input  PIX_READY, PATCH, PATCH_VALID, BUSY, PATCH_LAST
    );
`else
    modport slave (
        input  PIX_IN, PIX_VALID, PATCH_READY,
        output PIX_READY, PATCH, PATCH_VALID, BUSY
    );

    modport master (
        output PIX_IN, PIX_VALID, PATCH_READY,
        input  PIX_READY, PATCH, PATCH_VALID, BUSY
    );
`endif

endinterface

// File: rtl/patch_gen_line_buffer.sv
// patch_gen_line_buffer: one image row of delay (Depth x PixW). The slot addressed by the
// current column is read and overwritten on the same accepted pixel, so data_o is the
// pixel written exactly Depth writes earlier (same column, previous row).
//   clk_i   - clock
//   wr_en_i - pixel accepted this cycle
//   addr_i  - current column
//   data_i  - pixel entering this row delay
//   data_o  - pixel from the previous row, same column
// Contents are not reset; rows older than the frame start are never used.
module patch_gen_line_buffer
    import patch_gen_pkg::*;
#(
    parameter int unsigned Depth = 28,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [PixW-1:0]  data_i,
    output logic [PixW-1:0]  data_o
);

    logic [PixW-1:0] mem_q [Depth];

    assign data_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= data_i;
        end
    end

endmodule

// File: rtl/patch_gen.sv
// patch_gen: turns a raster pixel stream into a stream of KxK windows (stride 1, no
// padding). K-1 row delay lines feed a KxK window register that shifts left one column
// per accepted pixel; each completed window is copied into a skid-free output register.
//   CLK, rst_n - clock, asynchronous active-low reset
//   bus        - patch_gen_if.slave: pixel stream in, patch stream out, BUSY
// Optional feature: define PATCH_GEN_LAST_EN to add PATCH_LAST, flagging the final
// patch of each frame.
module patch_gen
    import patch_gen_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IMG_WIDTH   = 28,
    parameter int unsigned IMG_HEIGHT  = 28
) (
    input logic        CLK,
    input logic        rst_n,
    patch_gen_if.slave bus
);

    localparam int unsigned K      = KERNEL_SIZE;
    localparam int unsigned ColW   = $clog2(IMG_WIDTH);
    localparam int unsigned RowW   = $clog2(IMG_HEIGHT);
    localparam int unsigned PatchW = K * K * PixW;

    localparam logic [ColW-1:0] ColLast  = ColW'(IMG_WIDTH - 1);
    localparam logic [ColW-1:0] ColFirst = ColW'(K - 1);
    localparam logic [RowW-1:0] RowLast  = RowW'(IMG_HEIGHT - 1);
    localparam logic [RowW-1:0] RowFirst = RowW'(K - 1);

    typedef logic [PixW-1:0] pix_t;

    state_e               state_q, state_d;
    logic [ColW-1:0]      col_q, col_d;
    logic [RowW-1:0]      row_q, row_d;
    pix_t [K-1:0][K-1:0]  win_q, win_d;      // [row][col], row 0 = oldest
    pix_t [K-1:0][K-1:0]  win_shift;
    logic [PatchW-1:0]    patch_q, patch_d;
    logic [PatchW-1:0]    patch_load;
    logic                 patch_valid_q, patch_valid_d;

    logic pix_ready;
    logic pix_fire;
    logic patch_fire;
    logic load;
    logic last_pix;

    pix_t         lb_in  [K-1];
    pix_t         lb_out [K-1];
    pix_t [K-1:0] new_col;                   // new_col[K-1] is the incoming pixel

    // Handshakes; PIX_READY depends only on registered state and PATCH_READY.
    assign pix_ready  = (state_q != StHoldLast) && (!patch_valid_q || bus.PATCH_READY);
    assign pix_fire   = bus.PIX_VALID && pix_ready;
    assign patch_fire = patch_valid_q && bus.PATCH_READY;
    assign last_pix   = (col_q == ColLast) && (row_q == RowLast);
    // Only windows lying completely inside one row band are emitted.
    assign load       = pix_fire && (col_q >= ColFirst) && (row_q >= RowFirst);

    // Row delay chain: delay line j holds the row j+1 above the current one.
    for (genvar j = 0; j < K - 1; j++) begin : g_lb
        if (j == 0) begin : g_head
            assign lb_in[j] = bus.PIX_IN;
        end else begin : g_tail
            assign lb_in[j] = lb_out[j-1];
        end

        patch_gen_line_buffer #(
            .Depth (IMG_WIDTH),
            .AddrW (ColW)
        ) u_line_buffer (
            .clk_i   (CLK),
            .wr_en_i (pix_fire),
            .addr_i  (col_q),
            .data_i  (lb_in[j]),
            .data_o  (lb_out[j])
        );
    end

    always_comb begin
        new_col      = '0;
        new_col[K-1] = bus.PIX_IN;
        for (int unsigned j = 0; j < K - 1; j++) begin
            new_col[K-2-j] = lb_out[j];
        end
    end

    // Window after shifting in the incoming column.
    always_comb begin
        win_shift = win_q;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_shift[r][c] = win_q[r][c+1];
            end
            win_shift[r][K-1] = new_col[r];
        end
    end

    always_comb begin
        patch_load = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                patch_load[patch_idx(r, c, K)*PixW +: PixW] = win_shift[r][c];
            end
        end
    end

    // Datapath and counters.
    always_comb begin
        win_d         = win_q;
        col_d         = col_q;
        row_d         = row_q;
        patch_d       = patch_q;
        patch_valid_d = patch_valid_q;

        if (pix_fire) begin
            win_d = win_shift;
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A load in the same cycle as a take keeps PATCH_VALID high with new data.
        if (load) begin
            patch_d       = patch_load;
            patch_valid_d = 1'b1;
        end else if (patch_fire) begin
            patch_valid_d = 1'b0;
        end
    end

    // Frame FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pix_fire) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (pix_fire && last_pix) begin
                    state_d = StHoldLast;
                end
            end
            StHoldLast: begin
                if (patch_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_q         <= '0;
            win_q         <= '0;
            patch_q       <= '0;
            patch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            win_q         <= win_d;
            patch_q       <= patch_d;
            patch_valid_q <= patch_valid_d;
        end
    end

    assign bus.PIX_READY   = pix_ready;
    assign bus.PATCH       = patch_q;
    assign bus.PATCH_VALID = patch_valid_q;
    assign bus.BUSY        = (state_q != StIdle);

`ifdef PATCH_GEN_LAST_EN
    logic patch_last_q, patch_last_d;

    // Travels with the patch register; cleared when a patch leaves without a replacement.
    always_comb begin
        patch_last_d = patch_last_q;
        if (load) begin
            patch_last_d = last_pix;
        end else if (patch_fire) begin
            patch_last_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            patch_last_q <= 1'b0;
        end else begin
            patch_last_q <= patch_last_d;
        end
    end

    assign bus.PATCH_LAST = patch_last_q;
`endif

endmodule

// File: tb/tb_patch_gen.sv
module tb_patch_gen;

    typedef struct packed {
        logic [143:0] data;
        logic         last;
    } exp_t;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int seen1  = 0;
    int seen2  = 0;
    logic busy2_chk = 1'b0;

    exp_t q1[$];
    exp_t q2[$];

    patch_gen_if #(.KERNEL_SIZE(3)) bus ();
    patch_gen_if #(.KERNEL_SIZE(3)) bus2 ();

    patch_gen #(
        .KERNEL_SIZE (3),
        .IMG_WIDTH   (4),
        .IMG_HEIGHT  (4)
    ) u_dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    patch_gen #(
        .KERNEL_SIZE (3),
        .IMG_WIDTH   (28),
        .IMG_HEIGHT  (28)
    ) u_dut28 (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event, expected normal completion", name);
    endtask

    function automatic logic [143:0] pack9(input int e0, input int e1, input int e2,
                                           input int e3, input int e4, input int e5,
                                           input int e6, input int e7, input int e8);
        logic [143:0] v;
        v = {16'(e8), 16'(e7), 16'(e6), 16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
        return v;
    endfunction

    // Window whose top-left pixel sits at (r0, c0) in a frame where pixel (r,c) = base+r*w+c.
    function automatic logic [143:0] win_exp(input int base, input int w, input int r0,
                                             input int c0);
        logic [143:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v[(r*3+c)*16 +: 16] = 16'(base + (r0 + r) * w + c0 + c);
            end
        end
        return v;
    endfunction

    function automatic void push_frame4(input int base);
        for (int r0 = 0; r0 < 2; r0++) begin
            for (int c0 = 0; c0 < 2; c0++) begin
                q1.push_back('{data: win_exp(base, 4, r0, c0), last: (r0 == 1 && c0 == 1)});
            end
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the pixel was taken.
    task automatic send_pix(input int v);
        int   g;
        logic acc;
        g = 0;
        bus.PIX_IN    = 16'(v);
        bus.PIX_VALID = 1'b1;
        forever begin
            #1;
            acc = bus.PIX_READY;
            @(negedge clk);
            if (acc) break;
            g++;
            if (g > 200) begin
                fail_now("pix_accept_timeout");
                break;
            end
        end
        bus.PIX_VALID = 1'b0;
    endtask

    task automatic send_pix2(input int v);
        int   g;
        logic acc;
        g = 0;
        bus2.PIX_IN    = 16'(v);
        bus2.PIX_VALID = 1'b1;
        forever begin
            #1;
            acc = bus2.PIX_READY;
            @(negedge clk);
            if (acc) break;
            g++;
            if (g > 200) begin
                fail_now("pix2_accept_timeout");
                break;
            end
        end
        bus2.PIX_VALID = 1'b0;
    endtask

    task automatic send_frame4(input int base);
        for (int i = 0; i < 16; i++) send_pix(base + i);
    endtask

    task automatic wait_idle1();
        int g;
        g = 0;
        while ((bus.BUSY || q1.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) fail_now("wait_idle_timeout");
    endtask

    // Monitor for the 4x4 instance.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (bus.PATCH_VALID && bus.PATCH_READY) begin
            seen1++;
            if (q1.size() == 0) begin
                fail_now("patch_unexpected");
            end else begin
                e = q1.pop_front();
                check("patch_data", bus.PATCH, e.data);
`ifdef PATCH_GEN_LAST_EN
                check("patch_last", 144'(bus.PATCH_LAST), 144'(e.last));
`endif
            end
        end
    end

    // Monitor for the 28x28 instance; also checks BUSY one cycle after the final take.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (busy2_chk) begin
            busy2_chk = 1'b0;
            check("busy_after_last", 144'(bus2.BUSY), 144'(0));
        end
        if (bus2.PATCH_VALID && bus2.PATCH_READY) begin
            seen2++;
            if (q2.size() == 0) begin
                fail_now("patch28_unexpected");
            end else begin
                e = q2.pop_front();
                check("patch28_data", bus2.PATCH, e.data);
`ifdef PATCH_GEN_LAST_EN
                check("patch28_last", 144'(bus2.PATCH_LAST), 144'(e.last));
`endif
            end
            if (seen2 == 676) begin
                check("busy_at_last", 144'(bus2.BUSY), 144'(1));
                busy2_chk = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   start;
        int   g;
        logic [143:0] held;

        rst_n            = 1'b0;
        bus.PIX_IN       = '0;
        bus.PIX_VALID    = 1'b0;
        bus.PATCH_READY  = 1'b1;
        bus2.PIX_IN      = '0;
        bus2.PIX_VALID   = 1'b0;
        bus2.PATCH_READY = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_patch_valid", 144'(bus.PATCH_VALID), 144'(0));
        check("rst_busy", 144'(bus.BUSY), 144'(0));
        check("rst_patch", bus.PATCH, 144'(0));
        check("rst_pix_ready", 144'(bus.PIX_READY), 144'(1));
        check("rst_busy28", 144'(bus2.BUSY), 144'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 0..15 with a consumer that is always ready.
        start = seen1;
        q1.push_back('{data: pack9(0, 1, 2, 4, 5, 6, 8, 9, 10), last: 1'b0});
        q1.push_back('{data: pack9(1, 2, 3, 5, 6, 7, 9, 10, 11), last: 1'b0});
        q1.push_back('{data: pack9(4, 5, 6, 8, 9, 10, 12, 13, 14), last: 1'b0});
        q1.push_back('{data: pack9(5, 6, 7, 9, 10, 11, 13, 14, 15), last: 1'b1});
        send_frame4(0);
        wait_idle1();
        check("frame_a_count", 144'(seen1 - start), 144'(4));

        // Same frame, consumer stalls 5 cycles once the first patch appears.
        start = seen1;
        push_frame4(0);
        fork
            send_frame4(0);
            begin
                g = 0;
                while (!bus.PATCH_VALID && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                if (g >= 200) fail_now("stall_wait_timeout");
                bus.PATCH_READY = 1'b0;
                held = bus.PATCH;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check("stall_pix_ready", 144'(bus.PIX_READY), 144'(0));
                    @(negedge clk);
                    check("stall_patch_stable", bus.PATCH, held);
                    check("stall_valid_held", 144'(bus.PATCH_VALID), 144'(1));
                end
                bus.PATCH_READY = 1'b1;
            end
        join
        wait_idle1();
        check("frame_b_count", 144'(seen1 - start), 144'(4));

        // Reset after pixel 7, then a fresh frame 100..115.
        start = seen1;
        for (int i = 0; i < 8; i++) send_pix(i);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_patches", 144'(seen1 - start), 144'(0));
        check("midrst_valid", 144'(bus.PATCH_VALID), 144'(0));
        check("midrst_busy", 144'(bus.BUSY), 144'(0));
        check("midrst_patch", bus.PATCH, 144'(0));
        rst_n = 1'b1;
        @(negedge clk);
        q1.push_back('{data: pack9(100, 101, 102, 104, 105, 106, 108, 109, 110), last: 1'b0});
        q1.push_back('{data: win_exp(100, 4, 0, 1), last: 1'b0});
        q1.push_back('{data: win_exp(100, 4, 1, 0), last: 1'b0});
        q1.push_back('{data: win_exp(100, 4, 1, 1), last: 1'b1});
        send_frame4(100);
        wait_idle1();
        check("frame_c_count", 144'(seen1 - start), 144'(4));

        // Two back-to-back frames; PIX_READY must drop while the final patch is pending.
        start = seen1;
        push_frame4(0);
        push_frame4(200);
        send_frame4(0);
        #1;
        check("hold_last_pix_ready", 144'(bus.PIX_READY), 144'(0));
        check("hold_last_busy", 144'(bus.BUSY), 144'(1));
        send_frame4(200);
        wait_idle1();
        check("frame_d_count", 144'(seen1 - start), 144'(8));

        // 28x28 continuous stream.
        for (int r0 = 0; r0 < 26; r0++) begin
            for (int c0 = 0; c0 < 26; c0++) begin
                q2.push_back('{data: win_exp(0, 28, r0, c0), last: (r0 == 25 && c0 == 25)});
            end
        end
        for (int i = 0; i < 784; i++) send_pix2(i);
        g = 0;
        while ((bus2.BUSY || q2.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) fail_now("wait_idle28_timeout");
        repeat (2) @(negedge clk);
        check("frame28_count", 144'(seen2), 144'(676));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
